hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core; it sequences the decode stage `D` and its register file. It shadows the destination registers of the instructions in flight in E, M and W, and compares them with the source registers of the instruction in D. From that comparison it drives the stall and bubble controls, the D-stage operand forward selects, the branch flush, and the register-file write enable and address fed to `D`.

---
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard controller (stall/bubble, operand forwarding, branch flush, regfile write port).
// Optional macro HAZARD_FORWARD_EN enables E/M/W bypassing so that only load-use hazards stall.
`default_nettype none

module hazard_ctrl #(
  parameter int NREG = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              instr,
  input  logic                     branch_taken,
  output logic                     stall,
  output logic                     bubble,
  output logic                     flush,
  output logic [1:0]               fwd_rs,
  output logic [1:0]               fwd_rt,
  output logic                     write,
  output logic [$clog2(NREG)-1:0]  wb_dest,
  output logic [31:0]              stall_cycles
);

  localparam int RW = $clog2(NREG);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [5:0]    opcode;
  logic [RW-1:0] src_rs, src_rt, dec_dest;
  logic          rs_used, rt_used, dec_load;
  logic          hazard;

  logic          e_valid_q, m_valid_q, w_valid_q;
  logic [RW-1:0] e_dest_q, m_dest_q, w_dest_q;
  logic          e_valid_d;
  logic [RW-1:0] e_dest_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;

  logic rs_e, rs_m, rs_w, rt_e, rt_m, rt_w;

  assign opcode = instr[31:26];
  assign src_rs = instr[21 +: RW];
  assign src_rt = instr[16 +: RW];

  always_comb begin
    rs_used  = 1'b0;
    rt_used  = 1'b0;
    dec_dest = '0;
    dec_load = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        rs_used  = 1'b1;
        rt_used  = 1'b1;
        dec_dest = instr[11 +: RW];
      end
      OP_LW: begin
        rs_used  = 1'b1;
        dec_dest = src_rt;
        dec_load = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic src_match(input logic used, input logic valid,
                                     input logic [RW-1:0] dest, input logic [RW-1:0] src);
    return used && valid && (dest == src) && (src != '0);
  endfunction

  assign rs_e = src_match(rs_used, e_valid_q, e_dest_q, src_rs);
  assign rs_m = src_match(rs_used, m_valid_q, m_dest_q, src_rs);
  assign rs_w = src_match(rs_used, w_valid_q, w_dest_q, src_rs);
  assign rt_e = src_match(rt_used, e_valid_q, e_dest_q, src_rt);
  assign rt_m = src_match(rt_used, m_valid_q, m_dest_q, src_rt);
  assign rt_w = src_match(rt_used, w_valid_q, w_dest_q, src_rt);

`ifdef HAZARD_FORWARD_EN
  logic e_load_q, e_load_d;

  // Youngest producer wins: E, then M, then W.
  function automatic logic [1:0] fwd_sel(input logic me, input logic mm, input logic mw);
    if (me)      return 2'd1;
    else if (mm) return 2'd2;
    else if (mw) return 2'd3;
    else         return 2'd0;
  endfunction

  assign hazard = e_load_q && (rs_e || rt_e);
  assign fwd_rs = hazard ? 2'd0 : fwd_sel(rs_e, rs_m, rs_w);
  assign fwd_rt = hazard ? 2'd0 : fwd_sel(rt_e, rt_m, rt_w);
  assign e_load_d = e_valid_d && dec_load;

  always_ff @(posedge clk) begin
    if (reset) e_load_q <= 1'b0;
    else       e_load_q <= e_load_d;
  end
`else
  // The register file does not bypass a same-cycle write, so W must also be waited out.
  assign hazard = rs_e || rs_m || rs_w || rt_e || rt_m || rt_w;
  assign fwd_rs = 2'd0;
  assign fwd_rt = 2'd0;
  logic unused_load;
  assign unused_load = dec_load;
`endif

  assign stall  = hazard;
  assign bubble = hazard;
  assign flush  = branch_taken && !hazard;

  assign e_valid_d      = !hazard && (dec_dest != '0);
  assign e_dest_d       = e_valid_d ? dec_dest : '0;
  assign stall_cycles_d = (hazard && (stall_cycles_q != 32'hFFFF_FFFF)) ? stall_cycles_q + 32'd1
                                                                       : stall_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q      <= 1'b0;
      m_valid_q      <= 1'b0;
      w_valid_q      <= 1'b0;
      e_dest_q       <= '0;
      m_dest_q       <= '0;
      w_dest_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      e_valid_q      <= e_valid_d;
      e_dest_q       <= e_dest_d;
      m_valid_q      <= e_valid_q;
      m_dest_q       <= e_dest_q;
      w_valid_q      <= m_valid_q;
      w_dest_q       <= m_dest_q;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign write        = w_valid_q;
  assign wb_dest      = w_dest_q;
  assign stall_cycles = stall_cycles_q;

  logic unused_instr;
  assign unused_instr = ^{instr[15:0]};

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl; expectations follow HAZARD_FORWARD_EN.
`default_nettype none

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        branch_taken = 1'b0;
  logic        stall, bubble, flush, write;
  logic [1:0]  fwd_rs, fwd_rt;
  logic [4:0]  wb_dest;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.NREG(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .branch_taken(branch_taken),
    .stall(stall), .bubble(bubble), .flush(flush), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .write(write), .wb_dest(wb_dest), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, 6'h20};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rt, input logic [4:0] base);
    return {6'h23, base, rt, 16'h0000};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rt, input logic [4:0] base);
    return {6'h2B, base, rt, 16'h0000};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h04, rs, rt, 16'h0000};
  endfunction

  // Advance one clock, then let inputs settle before the caller samples.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    instr = '0;
    branch_taken = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    instr = 32'h0022_1820;
    branch_taken = 1'b0;
    cyc();
    cyc();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got=%b exp=0", bubble); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin errors++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", fwd_rs, fwd_rt); end
    checks++; if (write !== 1'b0 || wb_dest !== 5'd0) begin errors++; $display("FAIL reset_write got=%b/%0d exp=0/0", write, wb_dest); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
    reset = 1'b0;
    drain();
  endtask

  task automatic test_raw;
    instr = rtype(5'd3, 5'd1, 5'd2);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_first_stall got=%b exp=0", stall); end
    cyc();
    instr = rtype(5'd4, 5'd3, 5'd3);
    #1;
`ifdef HAZARD_FORWARD_EN
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_stall got=%b exp=0", stall); end
    checks++; if (fwd_rs !== 2'd1 || fwd_rt !== 2'd1) begin errors++; $display("FAIL raw_fwd got=%0d/%0d exp=1/1", fwd_rs, fwd_rt); end
    cyc();
    instr = '0;
    cyc();
    checks++; if (write !== 1'b1 || wb_dest !== 5'd3) begin errors++; $display("FAIL raw_wb3 got=%b/%0d exp=1/3", write, wb_dest); end
    cyc();
    checks++; if (write !== 1'b1 || wb_dest !== 5'd4) begin errors++; $display("FAIL raw_wb4 got=%b/%0d exp=1/4", write, wb_dest); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL raw_cnt got=%0d exp=0", stall_cycles); end
`else
    for (int i = 0; i < 3; i++) begin
      checks++; if (stall !== 1'b1 || bubble !== 1'b1) begin errors++; $display("FAIL raw_stall%0d got=%b/%b exp=1/1", i, stall, bubble); end
      checks++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin errors++; $display("FAIL raw_fwd%0d got=%0d/%0d exp=0/0", i, fwd_rs, fwd_rt); end
      if (i == 2) begin
        checks++; if (write !== 1'b1 || wb_dest !== 5'd3) begin errors++; $display("FAIL raw_wb3 got=%b/%0d exp=1/3", write, wb_dest); end
      end
      cyc();
    end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_release got=%b exp=0", stall); end
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL raw_wb_once got=%b exp=0", write); end
    checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL raw_cnt got=%0d exp=3", stall_cycles); end
`endif
    drain();
  endtask

  task automatic test_load_use;
    instr = lw(5'd4, 5'd4);
    cyc();
    instr = sw(5'd4, 5'd9);
    #1;
`ifdef HAZARD_FORWARD_EN
    checks++; if (stall !== 1'b1 || bubble !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b/%b exp=1/1", stall, bubble); end
    cyc();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", stall); end
    checks++; if (fwd_rt !== 2'd2 || fwd_rs !== 2'd0) begin errors++; $display("FAIL lu_fwd got=%0d/%0d exp=0/2", fwd_rs, fwd_rt); end
`else
    for (int i = 0; i < 3; i++) begin
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall%0d got=%b exp=1", i, stall); end
      cyc();
    end
    checks++; if (stall !== 1'b0 || fwd_rt !== 2'd0) begin errors++; $display("FAIL lu_release got=%b/%0d exp=0/0", stall, fwd_rt); end
`endif
    drain();
  endtask

  task automatic test_reg0;
    instr = rtype(5'd0, 5'd5, 5'd7);
    cyc();
    instr = rtype(5'd1, 5'd0, 5'd0);
    #1;
    checks++; if (stall !== 1'b0 || fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin errors++; $display("FAIL r0_read got=%b/%0d/%0d exp=0/0/0", stall, fwd_rs, fwd_rt); end
    cyc();
    instr = sw(5'd5, 5'd6);
    cyc();
    instr = beq(5'd5, 5'd6);
    #1;
    checks++; if (stall !== 1'b0 || fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin errors++; $display("FAIL sw_beq got=%b/%0d/%0d exp=0/0/0", stall, fwd_rs, fwd_rt); end
    // The r0-writer would now sit in W; it must not produce a write.
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL r0_write got=%b exp=0", write); end
    drain();
  endtask

  task automatic test_branch;
    instr = rtype(5'd3, 5'd1, 5'd2);
    cyc();
    instr = '0;
    cyc();
    cyc();
    instr = beq(5'd3, 5'd0);
    branch_taken = 1'b1;
    #1;
`ifdef HAZARD_FORWARD_EN
    checks++; if (flush !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL br_w_flush got=%b/%b exp=1/0", flush, stall); end
    checks++; if (fwd_rs !== 2'd3) begin errors++; $display("FAIL br_w_fwd got=%0d exp=3", fwd_rs); end
`else
    checks++; if (flush !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL br_w_hold got=%b/%b exp=0/1", flush, stall); end
    cyc();
    checks++; if (flush !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL br_w_flush got=%b/%b exp=1/0", flush, stall); end
`endif
    drain();
    instr = lw(5'd3, 5'd1);
    cyc();
    instr = beq(5'd3, 5'd0);
    branch_taken = 1'b1;
    #1;
`ifdef HAZARD_FORWARD_EN
    checks++; if (flush !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL br_lu_hold got=%b/%b exp=0/1", flush, stall); end
    cyc();
    checks++; if (flush !== 1'b1 || fwd_rs !== 2'd2) begin errors++; $display("FAIL br_lu_flush got=%b/%0d exp=1/2", flush, fwd_rs); end
`else
    for (int i = 0; i < 3; i++) begin
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_lu_hold%0d got=%b exp=0", i, flush); end
      cyc();
    end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_lu_flush got=%b exp=1", flush); end
`endif
    drain();
  endtask

  task automatic test_reset_mid_stall;
`ifdef HAZARD_FORWARD_EN
    instr = lw(5'd4, 5'd4);
    cyc();
    instr = sw(5'd4, 5'd9);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_stall got=%b exp=1", stall); end
`else
    instr = rtype(5'd3, 5'd1, 5'd2);
    cyc();
    instr = rtype(5'd4, 5'd3, 5'd3);
    cyc();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_stall got=%b exp=1", stall); end
`endif
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_release got=%b exp=0", stall); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rms_cnt got=%0d exp=0", stall_cycles); end
    instr = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef HAZARD_FORWARD_EN
      checks++; if (write && wb_dest == 5'd4) begin errors++; $display("FAIL rms_wb%0d got=%b/%0d exp=no r4 write", i, write, wb_dest); end
`else
      checks++; if (write && wb_dest == 5'd3) begin errors++; $display("FAIL rms_wb%0d got=%b/%0d exp=no r3 write", i, write, wb_dest); end
`endif
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_load_use();
    test_reg0();
    test_branch();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
